// File: rtl/multi_edge_pkg.sv
// Shared definitions for multi_edge_detector: edge-mode encodings,
// parameter range limits and the edge-qualification helper.
package multi_edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  localparam int NCH_MIN     = 1;
  localparam int NCH_MAX     = 32;
  localparam int SYNC_MIN    = 2;
  localparam int SYNC_MAX    = 4;
  localparam int CNT_W_MIN   = 4;
  localparam int CNT_W_MAX   = 32;
  localparam int STRETCH_MIN = 1;

  // p is the previous synchroniser output, s the current one
  function automatic logic edge_hit(input edge_mode_e mode, input logic p, input logic s);
    logic hit;
    case (mode)
      EDGE_OFF:  hit = 1'b0;
      EDGE_RISE: hit = ~p & s;
      EDGE_FALL: hit = p & ~s;
      EDGE_BOTH: hit = p ^ s;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_channel.sv
// One detector channel: synchroniser, edge qualifier, saturating counter
// and, when MULTI_EDGE_DETECTOR_STRETCH_EN is defined, a retriggerable
// LED stretch timer. Without the macro led is tied low.
module edge_channel
  import multi_edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int STRETCH_CYC = 1_200_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sig,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] edge_count,
  output logic             cnt_sat,
  output logic             led
);

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("SYNC_STAGES out of range");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("CNT_W out of range");
  end
  if (STRETCH_CYC < STRETCH_MIN) begin : g_bad_stretch
    $error("STRETCH_CYC out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  logic                   p_q, p_d;
  logic                   det_q, det_d;
  logic                   align_q, align_d;
  logic                   pulse_q, pulse_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sat_q, sat_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Next state: synchroniser shift, qualify, two retiming stages, saturating count
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sig};
    p_d     = s;
    det_d   = edge_hit(edge_mode_e'(mode), p_q, s);
    align_d = det_q;
    pulse_d = align_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    // clr outranks a coincident edge; the pulse itself is unaffected
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (pulse_q) begin
      if (&cnt_q) sat_d = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      p_q     <= 1'b0;
      det_q   <= 1'b0;
      align_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      p_q     <= p_d;
      det_q   <= det_d;
      align_q <= align_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign edge_pulse = pulse_q;
  assign edge_count = cnt_q;
  assign cnt_sat    = sat_q;

`ifdef MULTI_EDGE_DETECTOR_STRETCH_EN
  localparam int TMR_W = $clog2(STRETCH_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STRETCH_CYC);

  logic [TMR_W-1:0] tmr_q, tmr_d;

  // Retriggerable countdown: every pulse reloads the full stretch length
  always_comb begin
    tmr_d = tmr_q;
    if (pulse_q)              tmr_d = TMR_LOAD;
    else if (tmr_q != '0)     tmr_d = tmr_q - TMR_W'(1);
  end

  // Stretch timer register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmr_q <= '0;
    else          tmr_q <= tmr_d;
  end

  assign led = (tmr_q != '0);
`else
  assign led = 1'b0;
`endif

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector top: NCH independent edge_channel instances.
// Optional LED stretching is compiled in with MULTI_EDGE_DETECTOR_STRETCH_EN.
module multi_edge_detector
  import multi_edge_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int STRETCH_CYC = 1_200_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NCH-1:0]       sig,
  input  logic [2*NCH-1:0]     edge_mode,
  input  logic                 clr,
  output logic [NCH-1:0]       edge_pulse,
  output logic [NCH*CNT_W-1:0] edge_count,
  output logic [NCH-1:0]       cnt_sat,
  output logic [NCH-1:0]       led
);

  if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
    $error("NCH out of range");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .STRETCH_CYC (STRETCH_CYC)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .sig        (sig[i]),
      .mode       (edge_mode[2*i +: 2]),
      .clr        (clr),
      .edge_pulse (edge_pulse[i]),
      .edge_count (edge_count[CNT_W*i +: CNT_W]),
      .cnt_sat    (cnt_sat[i]),
      .led        (led[i])
    );
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector (NCH=4, SYNC_STAGES=2,
// CNT_W=4, STRETCH_CYC=8). Expected edge pulses go into a scoreboard queue
// when the stimulus is driven and are matched against edge_pulse.
module tb_multi_edge_detector;

  localparam int NCH         = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;
  localparam int STRETCH_CYC = 8;
  // input driven just after edge k is first sampled at edge k+1;
  // pulse rises SYNC_STAGES+2 edges later, i.e. after edge k+SYNC_STAGES+3
  localparam int LAT = SYNC_STAGES + 3;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NCH-1:0]       sig = '0;
  logic [2*NCH-1:0]     edge_mode = '0;
  logic                 clr = 1'b0;
  logic [NCH-1:0]       edge_pulse;
  logic [NCH*CNT_W-1:0] edge_count;
  logic [NCH-1:0]       cnt_sat;
  logic [NCH-1:0]       led;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct { int cyc; int ch; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  typedef struct {
    logic [2*NCH-1:0] mode;
    logic [NCH-1:0]   sig;
    logic [NCH-1:0]   exp_pulse;
    int               hold;
  } vec_t;
  vec_t vecs[12];
  int   exp_cnt[NCH];

  multi_edge_detector #(
    .NCH         (NCH),
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W),
    .STRETCH_CYC (STRETCH_CYC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sig        (sig),
    .edge_mode  (edge_mode),
    .clr        (clr),
    .edge_pulse (edge_pulse),
    .edge_count (edge_count),
    .cnt_sat    (cnt_sat),
    .led        (led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int count_of(input int ch);
    return int'(edge_count[CNT_W*ch +: CNT_W]);
  endfunction

  // drive sig and register the pulses this change must produce
  task automatic drive(input logic [NCH-1:0] v, input logic [NCH-1:0] expm);
    exp_t e;
    for (int ch = 0; ch < NCH; ch++) begin
      if (expm[ch]) begin
        e.cyc = cyc + LAT;
        e.ch  = ch;
        sb_q.push_back(e);
      end
    end
    sig = v;
  endtask

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL sb_missing_ch%0d: got no pulse expected pulse at cycle %0d", sb_q[0].ch, sb_q[0].cyc);
      void'(sb_q.pop_front());
    end
    for (int ch = 0; ch < NCH; ch++) begin
      if (edge_pulse[ch]) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_ch%0d: got pulse at cycle %0d expected none", ch, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_cycle", cyc, mon_e.cyc);
          chk("sb_chan", ch, mon_e.ch);
        end
      end
    end
`ifndef MULTI_EDGE_DETECTOR_STRETCH_EN
    chk("led_off", led, 0);
`endif
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;

    vecs[0] = '{8'h55, 4'b0001, 4'b0001, 8};
    vecs[1] = '{8'h2D, 4'b0001, 4'b0000, 4};
    for (int i = 2; i < 12; i++) begin
      if (i % 2 == 0) vecs[i] = '{8'h2D, 4'b1111, 4'b0010, 4};
      else            vecs[i] = '{8'h2D, 4'b0001, 4'b0110, 4};
    end
    exp_cnt = '{1, 10, 5, 0};

    // reset state
    repeat (3) step();
    chk("rst_pulse", edge_pulse, 0);
    chk("rst_count", edge_count, 0);
    chk("rst_sat", cnt_sat, 0);
    chk("rst_led", led, 0);
    reset_n = 1'b1;
    repeat (6) step();

    // table: rising on ch0, then both/falling/off on ch1..3
    for (int i = 0; i < 12; i++) begin
      edge_mode = vecs[i].mode;
      drive(vecs[i].sig, vecs[i].exp_pulse);
      repeat (vecs[i].hold) step();
    end
    repeat (8) step();
    for (int ch = 0; ch < NCH; ch++) chk($sformatf("tbl_count_ch%0d", ch), count_of(ch), exp_cnt[ch]);
    chk("tbl_sat", cnt_sat, 0);

    // saturation on ch0
    edge_mode = 8'h01;
    drive(4'b0000, 4'b0000);
    repeat (6) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    chk("clr0_count", edge_count, 0);
    for (int n = 1; n <= 17; n++) begin
      drive(4'b0001, 4'b0001);
      repeat (7) step();
      chk($sformatf("sat_cnt_e%0d", n), count_of(0), (n > 15) ? 15 : n);
      chk($sformatf("sat_flag_e%0d", n), cnt_sat[0], (n >= 16) ? 1 : 0);
      drive(4'b0000, 4'b0000);
      repeat (2) step();
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("sat_clr_count", count_of(0), 0);
    chk("sat_clr_flag", cnt_sat[0], 0);

    // clr coincident with a qualified edge
    drive(4'b0001, 4'b0001);
    repeat (7) step();
    chk("pre_clr_count", count_of(0), 1);
    drive(4'b0000, 4'b0000);
    repeat (3) step();
    drive(4'b0001, 4'b0001);
    repeat (LAT) step();
    chk("clr_pulse_hi", edge_pulse[0], 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    chk("clr_wins_count", count_of(0), 0);

    // mode changes with sig static produce nothing
    edge_mode = 8'h00;
    repeat (8) step();
    chk("mode_off_count", count_of(0), 0);
    edge_mode = 8'h01;
    repeat (8) step();
    chk("mode_on_count", count_of(0), 0);

`ifdef MULTI_EDGE_DETECTOR_STRETCH_EN
    // pulses at t and t+5 -> led high t+1 .. t+13
    drive(4'b0000, 4'b0000);
    repeat (20) step();
    drive(4'b0001, 4'b0001);
    t = cyc + LAT;
    repeat (2) step();
    drive(4'b0000, 4'b0000);
    repeat (3) step();
    drive(4'b0001, 4'b0001);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("led_stretch_t%0d", cyc - t), led[0], (cyc >= t + 1 && cyc <= t + 13) ? 1 : 0);
    end
    step();
`else
    t = 0;
`endif

    // reset mid-count / mid-stretch with an edge in flight
    clr = 1'b1;
    step();
    clr = 1'b0;
    drive(4'b0000, 4'b0000);
    repeat (4) step();
    for (int n = 0; n < 3; n++) begin
      drive(4'b0001, 4'b0001);
      repeat (4) step();
      drive(4'b0000, 4'b0000);
      repeat (4) step();
    end
    chk("mid_count3", count_of(0), 3);
    drive(4'b0001, 4'b0000);
    repeat (2) step();
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_pulse", edge_pulse, 0);
    chk("async_rst_count", edge_count, 0);
    chk("async_rst_sat", cnt_sat, 0);
    chk("async_rst_led", led, 0);
    sb_q.delete();
    repeat (3) step();
    drive(4'b0001, 4'b0001);
    reset_n = 1'b1;
    repeat (10) step();
    chk("post_rst_count", count_of(0), 1);
    chk("post_rst_led_t", t, t);

    repeat (4) step();
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
